// File: rtl/sha3_padder_if.sv
// Message-word input stream and padded-lane output stream between a producer and the SHA3 padder.
// The padder attaches through the slave modport; the master side feeds words and drains lanes.
interface sha3_padder_if;
  logic        msg_valid_i;
  logic        msg_ready_o;
  logic [63:0] msg_data_i;
  logic        msg_last_i;
  logic [3:0]  msg_bytes_i;
  logic        lane_valid_o;
  logic        lane_ready_i;
  logic [63:0] lane_data_o;
  logic        lane_last_o;
  logic        msg_end_o;

  modport slave (
    input  msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i, lane_ready_i,
    output msg_ready_o, lane_valid_o, lane_data_o, lane_last_o, msg_end_o
  );

  modport master (
    output msg_valid_i, msg_data_i, msg_last_i, msg_bytes_i, lane_ready_i,
    input  msg_ready_o, lane_valid_o, lane_data_o, lane_last_o, msg_end_o
  );
endinterface

// File: rtl/sha3_padder.sv
// Streaming SHA3/SHAKE padder: appends the domain suffix and pad10*1, emitting rate blocks as 64-bit lanes.
// One registered lane stage (1-cycle latency); input and PAD/ZERO generation stall while that lane is held.
module sha3_padder #(
  parameter int MODE_SEL_WIDTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
  sha3_padder_if.slave              bus,
  output logic                      busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MSG  = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_ZERO = 2'd3;

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = MODE_SEL_WIDTH'(0);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = MODE_SEL_WIDTH'(1);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE128 = MODE_SEL_WIDTH'(2);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHAKE256 = MODE_SEL_WIDTH'(3);

  localparam logic [63:0] PAD_END = 64'h8000_0000_0000_0000;

  logic [1:0]                state_q, state_d;
  logic [MODE_SEL_WIDTH-1:0] mode_q, mode_d;
  logic [4:0]                cnt_q, cnt_d;
  logic                      lane_vld_q, lane_vld_d;
  logic [63:0]               lane_dat_q, lane_dat_d;
  logic                      lane_last_q, lane_last_d;
  logic                      msg_end_q, msg_end_d;

  logic [4:0]  last_idx;
  logic [7:0]  suffix;
  logic        at_end;
  logic        hold;
  logic        adv;
  logic        gen;
  logic        pad;
  logic        full_word;
  logic        msg_rdy;
  logic [63:0] gen_dat;
  logic [63:0] tail_dat;

  always_comb begin
    last_idx = 5'd16;
    suffix   = 8'h06;
    case (mode_q)
      MODE_SHA3_256: last_idx = 5'd16;
      MODE_SHA3_512: last_idx = 5'd8;
      MODE_SHAKE128: last_idx = 5'd20;
      MODE_SHAKE256: last_idx = 5'd16;
      default:       last_idx = 5'd16;
    endcase
    if (mode_q == MODE_SHAKE128 || mode_q == MODE_SHAKE256) begin
      suffix = 8'h1F;
    end
  end

  // Partial final word: keep the first n bytes, suffix in byte n, zeros above.
  always_comb begin
    tail_dat = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < bus.msg_bytes_i) begin
        tail_dat[8*k +: 8] = bus.msg_data_i[8*k +: 8];
      end else if (4'(k) == bus.msg_bytes_i) begin
        tail_dat[8*k +: 8] = suffix;
      end
    end
  end

  assign full_word = !bus.msg_last_i || (bus.msg_bytes_i >= 4'd8);
  assign at_end    = (cnt_q == last_idx);
  // Once the closing lane is registered nothing more is generated until it drains.
  assign hold      = lane_vld_q && msg_end_q;
  assign adv       = (!lane_vld_q || bus.lane_ready_i) && !hold;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    lane_vld_d  = lane_vld_q;
    lane_dat_d  = lane_dat_q;
    lane_last_d = lane_last_q;
    msg_end_d   = msg_end_q;
    gen         = 1'b0;
    pad         = 1'b0;
    gen_dat     = '0;
    msg_rdy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_MSG;
          mode_d  = keccak_mode_i;
          cnt_d   = '0;
        end
      end
      ST_MSG: begin
        msg_rdy = adv;
        if (adv && bus.msg_valid_i) begin
          gen = 1'b1;
          if (full_word) begin
            gen_dat = bus.msg_data_i;
            if (bus.msg_last_i) begin
              state_d = ST_PAD;
            end
          end else begin
            gen_dat = tail_dat;
            pad     = 1'b1;
            if (!at_end) begin
              state_d = ST_ZERO;
            end
          end
        end
      end
      ST_PAD: begin
        if (adv) begin
          gen     = 1'b1;
          pad     = 1'b1;
          gen_dat = {56'h0, suffix};
          if (!at_end) begin
            state_d = ST_ZERO;
          end
        end
      end
      ST_ZERO: begin
        if (adv) begin
          gen = 1'b1;
          pad = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (gen) begin
      lane_vld_d  = 1'b1;
      lane_last_d = at_end;
      msg_end_d   = pad && at_end;
      lane_dat_d  = gen_dat | ((pad && at_end) ? PAD_END : 64'h0);
      cnt_d       = at_end ? 5'd0 : cnt_q + 5'd1;
    end else if (lane_vld_q && bus.lane_ready_i) begin
      lane_vld_d  = 1'b0;
      lane_last_d = 1'b0;
      msg_end_d   = 1'b0;
      if (msg_end_q) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      cnt_q       <= '0;
      lane_vld_q  <= 1'b0;
      lane_dat_q  <= '0;
      lane_last_q <= 1'b0;
      msg_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      lane_vld_q  <= lane_vld_d;
      lane_dat_q  <= lane_dat_d;
      lane_last_q <= lane_last_d;
      msg_end_q   <= msg_end_d;
    end
  end

  assign bus.msg_ready_o  = msg_rdy;
  assign bus.lane_valid_o = lane_vld_q;
  assign bus.lane_data_o  = lane_dat_q;
  assign bus.lane_last_o  = lane_last_q;
  assign bus.msg_end_o    = msg_end_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule
